// File: rtl/tx_stream_sequencer_pkg.sv
// rtl/tx_stream_sequencer_pkg.sv - shared constants and FSM encoding for the TX stream sequencer
//   TX_WIDTH            : default SI word width
//   DEFAULT_HEADER_MARK : header word base, channel index ORed into the low bits
//   tx_state_e          : IDLE / HEADER / STREAM / TRAILER
//   idx_width()         : bit width of a channel index for a given channel count
package tx_stream_sequencer_pkg;

  localparam int         TX_WIDTH            = 8;
  localparam logic [7:0] DEFAULT_HEADER_MARK = 8'hA0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_STREAM  = 2'd2,
    ST_TRAILER = 2'd3
  } tx_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_stream_sequencer_rr_pending_select.sv
// rtl/tx_stream_sequencer_rr_pending_select.sv - cyclic first-pending picker starting at a pointer
//   pending_i : request vector, one bit per channel
//   ptr_i     : index where the cyclic search starts
//   idx_o     : first pending index at or after ptr_i (wrapping)
//   found_o   : high when any pending bit is set
module rr_pending_select
  import tx_stream_sequencer_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  pending_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  always_comb begin
    int j;
    idx_o   = '0;
    found_o = 1'b0;
    j       = 0;
    // Walk from the far end back toward ptr so the nearest pending index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      if (pending_i[j]) begin
        idx_o   = IW'(j);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_stream_sequencer.sv
// rtl/tx_stream_sequencer.sv - round-robin N-channel framer onto the FT245 SI TX port
//   clk_i, rst          : clock, synchronous active-high reset
//   rqst_ch_i, abort_i  : per-channel request pulses, clear-all pulse
//   ch_data_i/ch_rdy_i/ch_eof_i/ch_ack_o : per-channel buffer streams
//   tx_data_o/tx_rdy_o/tx_ack_i          : SI transmit handshake
//   pending_o, busy_o   : latched requests, FSM not idle
//   Optional macro TX_STREAM_TRAILER_EN adds a saturating word-count trailer after EOF.
module tx_stream_sequencer
  import tx_stream_sequencer_pkg::*;
#(
  parameter int                    NUM_CH      = 2,
  parameter int                    DATA_WIDTH  = TX_WIDTH,
  parameter logic [DATA_WIDTH-1:0] HEADER_MARK = DATA_WIDTH'(DEFAULT_HEADER_MARK),
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                         clk_i,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            rqst_ch_i,
  input  logic                         abort_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]            ch_rdy_i,
  input  logic [NUM_CH-1:0]            ch_eof_i,
  output logic [NUM_CH-1:0]            ch_ack_o,
  output logic [DATA_WIDTH-1:0]        tx_data_o,
  output logic                         tx_rdy_o,
  input  logic                         tx_ack_i,
  output logic [NUM_CH-1:0]            pending_o,
  output logic                         busy_o
);

  localparam int IW = idx_width(NUM_CH);

  tx_state_e         state_q, state_d;
  logic [NUM_CH-1:0] pending_q, pending_d, clr;
  logic [IW-1:0]     ptr_q, ptr_d, sel_q, sel_d, pick_idx, sel_next;
  logic              pick_found;
  logic              sel_rdy, sel_eof, eof_xfer;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_pending_select #(.N(NUM_CH), .IW(IW)) u_rr (
    .pending_i (pending_q),
    .ptr_i     (ptr_q),
    .idx_o     (pick_idx),
    .found_o   (pick_found)
  );

  assign sel_data  = ch_data_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
  assign sel_rdy   = ch_rdy_i[sel_q];
  assign sel_eof   = ch_eof_i[sel_q];
  assign sel_next  = (sel_q == IW'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
  assign eof_xfer  = (state_q == ST_STREAM) && tx_ack_i && sel_rdy && sel_eof;
  assign pending_o = pending_q;

`ifdef TX_STREAM_TRAILER_EN
  localparam int TR_WORDS = (CNT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int TR_BITS  = TR_WORDS * DATA_WIDTH;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_inc;
  logic [TR_BITS-1:0]   tr_q;
  logic [7:0]           tr_left_q;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // The trailer shift register is loaded with the post-EOF count so the EOF word is included.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      cnt_q     <= '0;
      tr_q      <= '0;
      tr_left_q <= '0;
    end else begin
      if (state_q == ST_HEADER) begin
        cnt_q <= '0;
      end else if (state_q == ST_STREAM && tx_ack_i && sel_rdy) begin
        cnt_q <= cnt_inc;
      end
      if (eof_xfer) begin
        tr_q      <= TR_BITS'(cnt_inc);
        tr_left_q <= 8'(TR_WORDS);
      end else if (state_q == ST_TRAILER && tx_ack_i) begin
        tr_q      <= tr_q >> DATA_WIDTH;
        tr_left_q <= tr_left_q - 1'b1;
      end
    end
  end
`else
  localparam int unused_cnt_width = CNT_WIDTH;
`endif

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      ptr_q     <= '0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    clr       = '0;
    tx_rdy_o  = 1'b0;
    tx_data_o = '0;
    ch_ack_o  = '0;
    busy_o    = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          sel_d         = pick_idx;
          clr[pick_idx] = 1'b1;
          state_d       = ST_HEADER;
        end
      end
      ST_HEADER: begin
        tx_rdy_o  = 1'b1;
        tx_data_o = HEADER_MARK | DATA_WIDTH'(sel_q);
        if (tx_ack_i) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        tx_data_o       = sel_data;
        tx_rdy_o        = sel_rdy;
        ch_ack_o[sel_q] = tx_ack_i && sel_rdy;
        if (eof_xfer) begin
          ptr_d = sel_next;
`ifdef TX_STREAM_TRAILER_EN
          state_d = ST_TRAILER;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef TX_STREAM_TRAILER_EN
      ST_TRAILER: begin
        tx_rdy_o  = 1'b1;
        tx_data_o = tr_q[DATA_WIDTH-1:0];
        if (tx_ack_i && tr_left_q == 8'd1) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Clear-on-select happens before the OR so a request in the selection cycle re-queues.
    pending_d = (pending_q & ~clr) | rqst_ch_i;
    if (abort_i) pending_d = '0;
  end

endmodule
